// File: rtl/spi_arbiter_pkg.sv
// Shared types and helpers for the SPI requester arbiter.
package spi_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ISSUE     = 2'd1,
      ST_WAIT_BUSY = 2'd2,
      ST_TRANSFER  = 2'd3
   } state_e;

   localparam int unsigned CNT_W = 8;

   // Width of an index into n requesters, never narrower than one bit.
   function automatic int unsigned owner_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/spi_arbiter_rr_priority_picker.sv
// Round-robin search: first set request at or above the pointer, wrapping to 0.
module rr_priority_picker
   import spi_arbiter_pkg::*;
#(
   parameter  int unsigned NUM_REQ = 3,
   localparam int unsigned IW      = owner_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IW-1:0]      ptr_i,
   output logic               valid_o_c,
   output logic [IW-1:0]      idx_o_c
);

   logic [IW:0]   cand;
   logic [IW-1:0] cand_idx;

   always_comb begin
      valid_o_c = 1'b0;
      idx_o_c   = '0;
      cand      = '0;
      cand_idx  = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = {1'b0, ptr_i} + (IW+1)'(k);
         if (cand >= (IW+1)'(NUM_REQ)) begin
            cand = cand - (IW+1)'(NUM_REQ);
         end
         cand_idx = IW'(cand);
         if (!valid_o_c && req_i[cand_idx]) begin
            valid_o_c = 1'b1;
            idx_o_c   = cand_idx;
         end
      end
   end

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin arbiter granting one requester at a time access to an SPI serializer,
// with a start-of-transfer timeout when the serializer never goes busy.
module spi_arbiter
   import spi_arbiter_pkg::*;
#(
   parameter  int unsigned NUM_REQ       = 3,
   parameter  int unsigned DATA_WIDTH    = 16,
   parameter  int unsigned START_TIMEOUT = 15,
   localparam int unsigned OW            = owner_w(NUM_REQ)
) (
   input  logic                                i_Clk,
   input  logic                                i_Rst_n,
   input  logic [NUM_REQ-1:0]                  i_Req,
   input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  i_Data,
   output logic [NUM_REQ-1:0]                  o_Grant,
   output logic [NUM_REQ-1:0]                  o_Done,
   output logic                                o_Err,
   output logic                                o_Data_Valid,
   output logic [DATA_WIDTH-1:0]               o_Data,
   input  logic                                i_Busy,
   output logic [OW-1:0]                       o_Owner
);

   state_e                  state_q, state_d;
   logic [OW-1:0]           ptr_q, ptr_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [NUM_REQ-1:0]      grant_q, grant_d;
   logic [NUM_REQ-1:0]      done_q, done_d;
   logic                    err_q, err_d;
   logic                    dv_q, dv_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;
   logic [OW-1:0]           owner_q, owner_d;

   logic                    pick_valid_c;
   logic [OW-1:0]           pick_idx_c;
   logic [OW:0]             ptr_inc_c;

   rr_priority_picker #(
      .NUM_REQ (NUM_REQ)
   ) u_picker (
      .req_i     (i_Req),
      .ptr_i     (ptr_q),
      .valid_o_c (pick_valid_c),
      .idx_o_c   (pick_idx_c)
   );

   assign ptr_inc_c = (OW+1)'(pick_idx_c) + (OW+1)'(1);

   // Next-state and registered-output logic.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      grant_d = '0;
      done_d  = '0;
      err_d   = 1'b0;
      dv_d    = 1'b0;
      data_d  = data_q;
      owner_d = owner_q;

      case (state_q)
         ST_IDLE: begin
            if (!i_Busy && pick_valid_c) begin
               data_d  = i_Data[pick_idx_c];
               owner_d = pick_idx_c;
               grant_d = NUM_REQ'(1) << pick_idx_c;
               dv_d    = 1'b1;
               ptr_d   = (ptr_inc_c == (OW+1)'(NUM_REQ)) ? '0 : OW'(ptr_inc_c);
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            cnt_d   = '0;
            state_d = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            if (i_Busy) begin
               cnt_d   = '0;
               state_d = ST_TRANSFER;
            end else if (cnt_q == CNT_W'(START_TIMEOUT - 1)) begin
               cnt_d   = '0;
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_TRANSFER: begin
            if (!i_Busy) begin
               done_d  = NUM_REQ'(1) << owner_q;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         cnt_q   <= '0;
         grant_q <= '0;
         done_q  <= '0;
         err_q   <= 1'b0;
         dv_q    <= 1'b0;
         data_q  <= '0;
         owner_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         grant_q <= grant_d;
         done_q  <= done_d;
         err_q   <= err_d;
         dv_q    <= dv_d;
         data_q  <= data_d;
         owner_q <= owner_d;
      end
   end

   assign o_Grant      = grant_q;
   assign o_Done       = done_q;
   assign o_Err        = err_q;
   assign o_Data_Valid = dv_q;
   assign o_Data       = data_q;
   assign o_Owner      = owner_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter: single transfer, round-robin, timeout, external busy, reset abort.
module tb_spi_arbiter;

   logic              clk;
   logic              rst_n;
   logic [2:0]        req;
   logic [2:0][15:0]  data;
   logic              busy;
   logic [2:0]        o_grant;
   logic [2:0]        o_done;
   logic              o_err;
   logic              o_dv;
   logic [15:0]       o_data;
   logic [1:0]        o_owner;

   int checks = 0;
   int errors = 0;

   spi_arbiter #(
      .NUM_REQ       (3),
      .DATA_WIDTH    (16),
      .START_TIMEOUT (15)
   ) dut (
      .i_Clk        (clk),
      .i_Rst_n      (rst_n),
      .i_Req        (req),
      .i_Data       (data),
      .o_Grant      (o_grant),
      .o_Done       (o_done),
      .o_Err        (o_err),
      .o_Data_Valid (o_dv),
      .o_Data       (o_data),
      .i_Busy       (busy),
      .o_Owner      (o_owner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_grant"}, 32'(o_grant), 32'h0);
      chk({tag, "_done"},  32'(o_done),  32'h0);
      chk({tag, "_err"},   32'(o_err),   32'h0);
      chk({tag, "_dv"},    32'(o_dv),    32'h0);
      chk({tag, "_data"},  32'(o_data),  32'h0);
      chk({tag, "_owner"}, 32'(o_owner), 32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0]  exp_oh;
      logic [15:0] exp_data;

      rst_n = 1'b0;
      req   = '0;
      busy  = 1'b0;
      data  = '0;
      tick(3);
      chk_all_zero("reset");
      rst_n = 1'b1;

      // Single requester 1, serializer busy for 34 cycles.
      data[1] = 16'h0C01;
      req     = 3'b010;
      tick(1);
      chk("t1_grant", 32'(o_grant), 32'h2);
      chk("t1_owner", 32'(o_owner), 32'h1);
      chk("t1_data",  32'(o_data),  32'h0C01);
      chk("t1_dv",    32'(o_dv),    32'h1);
      req = '0;
      tick(1);
      chk("t1_dv_drop",    32'(o_dv),    32'h0);
      chk("t1_grant_drop", 32'(o_grant), 32'h0);
      busy = 1'b1;
      tick(17);
      chk("t1_no_done_mid", 32'(o_done), 32'h0);
      chk("t1_no_err_mid",  32'(o_err),  32'h0);
      tick(17);
      busy = 1'b0;
      tick(1);
      chk("t1_done", 32'(o_done), 32'h2);
      tick(1);
      chk("t1_done_pulse", 32'(o_done), 32'h0);
      chk("t1_data_hold",  32'(o_data), 32'h0C01);

      // Asynchronous reset clears outputs mid-cycle.
      #2 rst_n = 1'b0;
      #1;
      chk("rst2_owner", 32'(o_owner), 32'h0);
      chk("rst2_data",  32'(o_data),  32'h0);
      tick(1);
      rst_n = 1'b1;

      // All three requesting: grants 0,1,2,0,1 with a done between each.
      data = {16'hA002, 16'hA001, 16'hA000};
      req  = 3'b111;
      for (int k = 0; k < 5; k++) begin
         exp_oh   = 3'b001 << (k % 3);
         exp_data = 16'(32'hA000 + 32'(k % 3));
         tick(1);
         chk("rr_grant", 32'(o_grant), 32'(exp_oh));
         chk("rr_data",  32'(o_data),  32'(exp_data));
         tick(1);
         busy = 1'b1;
         tick(3);
         busy = 1'b0;
         tick(1);
         chk("rr_done", 32'(o_done), 32'(exp_oh));
      end
      req = '0;

      // Serializer never goes busy: error after 15 cycles in WAIT_BUSY.
      req = 3'b001;
      tick(1);
      chk("to_grant", 32'(o_grant), 32'h1);
      req = '0;
      tick(1);
      tick(14);
      chk("to_err_early", 32'(o_err), 32'h0);
      tick(1);
      chk("to_err",     32'(o_err),  32'h1);
      chk("to_no_done", 32'(o_done), 32'h0);
      tick(1);
      chk("to_err_pulse", 32'(o_err), 32'h0);
      req = 3'b011;
      tick(1);
      chk("to_ptr_adv", 32'(o_grant), 32'h2);
      req = '0;
      tick(1);
      busy = 1'b1;
      tick(1);
      busy = 1'b0;
      tick(1);
      chk("to_done2", 32'(o_done), 32'h2);

      // External busy blocks grants in IDLE.
      busy = 1'b1;
      req  = 3'b001;
      for (int k = 0; k < 20; k++) begin
         tick(1);
         chk("eb_no_grant", 32'(o_grant), 32'h0);
      end
      busy = 1'b0;
      tick(1);
      chk("eb_grant", 32'(o_grant), 32'h1);
      req = '0;
      tick(1);
      busy = 1'b1;
      tick(1);
      busy = 1'b0;
      tick(1);
      chk("eb_done", 32'(o_done), 32'h1);

      // Reset during TRANSFER aborts silently; pending requester 2 wins afterwards.
      data[1] = 16'h1111;
      req     = 3'b010;
      tick(1);
      chk("ra_grant", 32'(o_grant), 32'h2);
      req = '0;
      tick(1);
      busy = 1'b1;
      tick(3);
      data[2] = 16'hBEEF;
      req     = 3'b100;
      #2 rst_n = 1'b0;
      #1;
      chk_all_zero("ra_async");
      busy = 1'b0;
      tick(1);
      chk("ra_no_done", 32'(o_done),  32'h0);
      chk("ra_no_err",  32'(o_err),   32'h0);
      rst_n = 1'b1;
      chk("ra_no_early_grant", 32'(o_grant), 32'h0);
      tick(1);
      chk("ra_grant2", 32'(o_grant), 32'h4);
      chk("ra_owner2", 32'(o_owner), 32'h2);
      chk("ra_data2",  32'(o_data),  32'hBEEF);
      req = '0;
      tick(1);
      busy = 1'b1;
      tick(1);
      busy = 1'b0;
      tick(1);
      chk("ra_done2", 32'(o_done), 32'h4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
